// File: rtl/sipo_deser_pkg.sv
// Shared definitions for the serial deserializer and its bit counter.
// No logic; state encodings and default sizing only.
// Default WIDTH matches the upstream PISO shifter.
package sipo_deser_pkg;

   // Default frame width, kept equal to the PISO side of the link.
   localparam int SR_WIDTH = 4;
   // Default bit-counter width; 2**SR_CNT_W must exceed SR_WIDTH.
   localparam int SR_CNT_W = 3;

   // FSM encodings. ST_PAR is only reachable when PARITY_CHK_EN is defined.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_PAR   = 2'd2
   } state_e;

endpackage

// File: rtl/sipo_deser_bit_counter.sv
// Purpose: counts received data bits of a frame; tc flags the last data bit.
// Latency: clr/inc take effect at the next clock edge; tc is combinational from the count.
// Backpressure: none; the count holds whenever inc is low.
module bit_counter
   import sipo_deser_pkg::*;
#(
   parameter int WIDTH = SR_WIDTH,
   parameter int CNT_W = SR_CNT_W
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   input  logic inc,
   output logic tc
);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Next count: clear has priority over increment, otherwise hold.
   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (inc) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   // Count register with asynchronous active-low reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // Terminal count: the bit being sampled now is the last data bit.
   assign tc = (cnt_q == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/sipo_deser.sv
// Purpose: MSB-first serial-in/parallel-out deserializer with a decoupled output word register.
// Latency: a word appears on dout/dout_valid the cycle after its last bit (parity bit if PARITY_CHK_EN) is sampled.
// Backpressure: valid/ready on dout; a word completing while dout is held and not accepted is dropped and sets sticky overrun.
module sipo_deser
   import sipo_deser_pkg::*;
#(
   parameter int WIDTH = SR_WIDTH,
   parameter int CNT_W = SR_CNT_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             shift_en,
   input  logic             sin,
   output logic [WIDTH-1:0] dout,
   output logic             dout_valid,
   input  logic             dout_ready,
   output logic             overrun,
   input  logic             ovr_clr,
   output logic             parity_err
);

   state_e state_q, state_d;

`ifdef PARITY_CHK_EN
   // All WIDTH data bits must be held while the trailing parity bit is awaited.
   logic [WIDTH-1:0] shreg_q, shreg_d;
   logic [WIDTH-1:0] shifted;
   logic             perr_new;
   logic             parity_err_q, parity_err_d;
   assign shifted = {shreg_q[WIDTH-2:0], sin};
`else
   // Only WIDTH-1 bits need storage: the last bit goes straight into dout.
   logic [WIDTH-2:0] shreg_q, shreg_d;
   logic [WIDTH-1:0] shifted;
   assign shifted = {shreg_q, sin};
`endif

   logic [WIDTH-1:0] word_new;
   logic             complete;
   logic             cnt_clr, cnt_inc, cnt_tc;
   logic             transfer;

   logic [WIDTH-1:0] dout_q, dout_d;
   logic             dout_valid_q, dout_valid_d;
   logic             overrun_q, overrun_d;

   bit_counter #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W)
   ) u_bit_counter (
      .clk   (clk),
      .reset (reset),
      .clr   (cnt_clr),
      .inc   (cnt_inc),
      .tc    (cnt_tc)
   );

   // Frame FSM: start always (re)opens a frame; bits are taken only while shift_en is high.
   always_comb begin
      state_d  = state_q;
      shreg_d  = shreg_q;
      cnt_clr  = 1'b0;
      cnt_inc  = 1'b0;
      complete = 1'b0;
`ifdef PARITY_CHK_EN
      word_new = shreg_q;
      perr_new = 1'b0;
`else
      word_new = shifted;
`endif
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_SHIFT;
               cnt_clr = 1'b1;
            end
         end
         ST_SHIFT: begin
            if (start) begin
               // Abort the partial frame and restart counting; start beats shift_en.
               cnt_clr = 1'b1;
            end else if (shift_en) begin
`ifdef PARITY_CHK_EN
               shreg_d = shifted;
`else
               shreg_d = shifted[WIDTH-2:0];
`endif
               cnt_inc = 1'b1;
               if (cnt_tc) begin
`ifdef PARITY_CHK_EN
                  state_d  = ST_PAR;
`else
                  state_d  = ST_IDLE;
                  complete = 1'b1;
`endif
               end
            end
         end
`ifdef PARITY_CHK_EN
         ST_PAR: begin
            if (start) begin
               state_d = ST_SHIFT;
               cnt_clr = 1'b1;
            end else if (shift_en) begin
               // Even parity: XOR over data and parity bit is 0 for a clean frame.
               complete = 1'b1;
               word_new = shreg_q;
               perr_new = ^{shreg_q, sin};
               state_d  = ST_IDLE;
            end
         end
`endif
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign transfer = dout_valid_q & dout_ready;

   // Output word register: load on completion unless the held word is stuck, in which case flag overrun.
   always_comb begin
      dout_d       = dout_q;
      dout_valid_d = dout_valid_q;
      overrun_d    = overrun_q;
`ifdef PARITY_CHK_EN
      parity_err_d = parity_err_q;
`endif
      if (ovr_clr) begin
         overrun_d = 1'b0;
      end
      if (complete) begin
         if (!dout_valid_q || dout_ready) begin
            // Free slot, or the old word leaves this cycle: no bubble between words.
            dout_d       = word_new;
            dout_valid_d = 1'b1;
`ifdef PARITY_CHK_EN
            parity_err_d = perr_new;
`endif
         end else begin
            // Set wins over a simultaneous clear.
            overrun_d = 1'b1;
         end
      end else if (transfer) begin
         dout_valid_d = 1'b0;
      end
   end

   // State, shifter and output registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= ST_IDLE;
         shreg_q      <= '0;
         dout_q       <= '0;
         dout_valid_q <= 1'b0;
         overrun_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         shreg_q      <= shreg_d;
         dout_q       <= dout_d;
         dout_valid_q <= dout_valid_d;
         overrun_q    <= overrun_d;
      end
   end

`ifdef PARITY_CHK_EN
   // Parity result travels with the word it describes.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         parity_err_q <= 1'b0;
      end else begin
         parity_err_q <= parity_err_d;
      end
   end
   assign parity_err = parity_err_q;
`else
   assign parity_err = 1'b0;
`endif

   assign dout       = dout_q;
   assign dout_valid = dout_valid_q;
   assign overrun    = overrun_q;

endmodule
